// File: rtl/rgb_ball_stream_gen_pkg.sv
// Shared definitions for the RGB ball stream generator: colour codes,
// permutation codes and FSM state encodings.
package rgb_ball_stream_gen_pkg;

  typedef enum logic [1:0] {
    COL_G = 2'b00,
    COL_B = 2'b01,
    COL_R = 2'b10
  } colour_e;

  localparam logic [2:0] PERM_RGB = 3'd0;
  localparam logic [2:0] PERM_RBG = 3'd1;
  localparam logic [2:0] PERM_GRB = 3'd2;
  localparam logic [2:0] PERM_GBR = 3'd3;
  localparam logic [2:0] PERM_BRG = 3'd4;
  localparam logic [2:0] PERM_BGR = 3'd5;
  localparam logic [2:0] PERM_MAX = PERM_BGR;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GAP  = 3'd1,
    ST_C0   = 3'd2,
    ST_C1   = 3'd3,
    ST_C2   = 3'd4
  } state_e;

endpackage

// File: rtl/rgb_ball_stream_gen_perm_lut.sv
// Maps a triplet permutation code to its three ball colours and flags
// codes above the legal maximum.
module rgb_perm_lut
  import rgb_ball_stream_gen_pkg::*;
(
  input  logic [2:0] perm_i,
  output colour_e    col0_o,
  output colour_e    col1_o,
  output colour_e    col2_o,
  output logic       illegal_o
);

  always_comb begin
    col0_o    = COL_G;
    col1_o    = COL_G;
    col2_o    = COL_G;
    illegal_o = (perm_i > PERM_MAX);
    case (perm_i)
      PERM_RGB: begin col0_o = COL_R; col1_o = COL_G; col2_o = COL_B; end
      PERM_RBG: begin col0_o = COL_R; col1_o = COL_B; col2_o = COL_G; end
      PERM_GRB: begin col0_o = COL_G; col1_o = COL_R; col2_o = COL_B; end
      PERM_GBR: begin col0_o = COL_G; col1_o = COL_B; col2_o = COL_R; end
      PERM_BRG: begin col0_o = COL_B; col1_o = COL_R; col2_o = COL_G; end
      PERM_BGR: begin col0_o = COL_B; col1_o = COL_G; col2_o = COL_R; end
      default: ;
    endcase
  end

endmodule

// File: rtl/rgb_ball_stream_gen.sv
// Emits a filler run followed by one three-distinct-colour triplet per
// accepted command, with a cycle-aligned expected-detection pulse.
module rgb_ball_stream_gen
  import rgb_ball_stream_gen_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_req,
  input  logic [2:0]       cmd_perm,
  input  logic [3:0]       cmd_gap,
  output logic             cmd_rdy,
  output logic [1:0]       out_col,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             done,
  output logic             exp_det,
  output logic             err,
  output logic [CNT_W-1:0] tri_cnt
);

  state_e           state_q, state_d;
  colour_e          col0_q, col0_d;
  colour_e          col1_q, col1_d;
  colour_e          col2_q, col2_d;
  logic [3:0]       gap_q, gap_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  colour_e lutCol0, lutCol1, lutCol2;
  logic    lutIllegal;
  logic    handshake;
  colour_e colOut;

  rgb_perm_lut uPermLut (
    .perm_i    (cmd_perm),
    .col0_o    (lutCol0),
    .col1_o    (lutCol1),
    .col2_o    (lutCol2),
    .illegal_o (lutIllegal)
  );

  assign handshake = out_vld && out_rdy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      col0_q  <= COL_G;
      col1_q  <= COL_G;
      col2_q  <= COL_G;
      gap_q   <= 4'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      col0_q  <= col0_d;
      col1_q  <= col1_d;
      col2_q  <= col2_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Every non-idle state advances only on a handshake, so a stalled
  // consumer sees both state and colour frozen.
  always_comb begin
    state_d = state_q;
    col0_d  = col0_q;
    col1_d  = col1_q;
    col2_d  = col2_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_req) begin
          if (lutIllegal) begin
            err_d = 1'b1;
          end else begin
            col0_d  = lutCol0;
            col1_d  = lutCol1;
            col2_d  = lutCol2;
            gap_d   = cmd_gap;
            state_d = (cmd_gap == 4'd0) ? ST_C0 : ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (handshake) begin
          gap_d = gap_q - 4'd1;
          if (gap_q == 4'd1) state_d = ST_C0;
        end
      end
      ST_C0: if (handshake) state_d = ST_C1;
      ST_C1: if (handshake) state_d = ST_C2;
      ST_C2: begin
        if (handshake) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Filler reuses the first triplet colour so the run never forms a triplet.
  always_comb begin
    colOut = COL_G;
    case (state_q)
      ST_GAP, ST_C0: colOut = col0_q;
      ST_C1:         colOut = col1_q;
      ST_C2:         colOut = col2_q;
      default:       colOut = COL_G;
    endcase
  end

  assign out_col = colOut;
  assign out_vld = (state_q != ST_IDLE);
  assign cmd_rdy = (state_q == ST_IDLE);
  assign done    = done_q;
  assign exp_det = done_q;
  assign err     = err_q;
  assign tri_cnt = cnt_q;

endmodule

// File: doc/rgb_ball_stream_gen.md
# rgb_ball_stream_gen

Stimulus-side counterpart of the RGB ball detector: generates a 2-bit ball-colour stream containing exactly one three-distinct-colour triplet per command, preceded by a programmable run of filler balls. Sits upstream of the non-overlapping Moore RGB detector, both as a bench driver and as an on-chip self-test source. Emits a cycle-aligned expected-detection flag for direct comparison with the detector's output.

## Interface
Parameters:
- CNT_W, 8, width of the completed-triplet counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset
- cmd_req  input  1  command request
- cmd_perm  input  3  triplet permutation code, 0..5 legal
- cmd_gap  input  4  filler balls before the triplet, 0..15
- cmd_rdy  output  1  command accepted when cmd_req && cmd_rdy
- out_col  output  2  ball colour: G=00, B=01, R=10; 11 never driven
- out_vld  output  1  out_col valid
- out_rdy  input  1  consumer accepts the ball when out_vld && out_rdy
- done  output  1  one-cycle pulse after the last ball of a command is accepted
- exp_det  output  1  one-cycle pulse in the cycle a Moore detector clocked on accepted balls asserts det
- err  output  1  one-cycle pulse when an illegal cmd_perm is offered
- tri_cnt  output  CNT_W  count of completed triplets, wraps modulo 2^CNT_W

## Operation
- Permutation codes map to colours (first, second, third): 0 = R,G,B; 1 = R,B,G; 2 = G,R,B; 3 = G,B,R; 4 = B,R,G; 5 = B,G,R.
- FSM states: IDLE, GAP, C0, C1, C2.
- IDLE: cmd_rdy = 1 and out_vld = 0.
  - On cmd_req with perm ≤ 5: latch the three colours and gap, then go to GAP (gap > 0) or C0 (gap = 0).
  - On cmd_req with perm 6/7: err = 1 next cycle; stay IDLE; nothing is latched.
- GAP: emit the latched first colour. Decrement the gap counter per handshake; leave for C0 on the handshake that brings it to 0.
- C0, C1 and C2 emit the first, second and third colour. Each advances only on a handshake.
- C2 handshake: go to IDLE, increment tri_cnt, and pulse done and exp_det in the following cycle.
- Filler equals the first triplet colour. A single-colour run can never complete a triplet, and it leaves the non-overlapping detector in a single-colour state. Each command therefore produces exactly one detection.
- Backpressure:
  - While out_vld && !out_rdy, out_col and state are held stable.
  - out_vld never drops without a handshake, except on reset.
- cmd_req while busy is ignored, with no err; the requester must hold it.

## Timing
- Reset (rst low at a clock edge):
  - state goes to IDLE.
  - out_vld = 0, out_col = 00, done = 0, exp_det = 0, err = 0, tri_cnt = 0.
  - cmd_rdy = 1 from the first cycle after reset.
- Reset mid-command aborts it with no done, no exp_det and no tri_cnt change.
- Command accepted at edge E: out_vld is high from E+1.
- With out_rdy held high: gap+3 balls on consecutive cycles; done, exp_det and cmd_rdy are all high in the cycle after the last ball.
- Back-to-back: a command accepted in the done cycle starts its first ball on the next cycle, so there is one idle ball slot between commands.
- Each stall cycle (out_rdy low) delays everything downstream by exactly one cycle.
- tri_cnt wraps from 2^CNT_W−1 to 0.

## Structure
- A shared package holds:
  - colour constants G/B/R
  - permutation codes and the legal-max constant
  - FSM state encodings
- One combinational sub-module, rgb_perm_lut, maps cmd_perm to the three colours plus an illegal flag.

## Test plan
- perm=3, gap=0, out_rdy=1 → out_col G,B,R on three consecutive cycles; done and exp_det pulse the next cycle; tri_cnt = 1.
- perm=4, gap=2 → B,B,B,R,G; detector driven by the stream asserts det in exactly the exp_det cycle, once.
- perm=0, gap=1, out_rdy low for 2 cycles during C1 → G held stable both cycles, no extra balls; done delayed by 2 cycles.
- perm=6, then perm=7 → err pulse each time; cmd_rdy stays 1; out_vld stays 0; tri_cnt unchanged.
- Reset asserted during GAP of a gap=10 command → out_vld = 0 the next cycle, no done; tri_cnt stays 0; a new command then runs normally.
- 256 back-to-back perm=5, gap=0 commands with CNT_W=8 → tri_cnt wraps to 0; one idle slot between triplets; 256 detector hits.
